// File: rtl/eth_pdu_scheduler_if.sv
// Stream-in / sender-out signal bundle for eth_pdu_scheduler.
// The master side drives the i_* inputs and the slave (scheduler) drives the o_* outputs.
interface eth_pdu_scheduler_if #(
    parameter int DESC_AW = 2
);
    logic [7:0]       i_data;
    logic             i_wr;
    logic             i_din;
    logic             o_full;
    logic [10:0]      i_pdu_size;
    logic [15:0]      i_cmd;
    logic             i_cmd_finish;
    logic [15:0]      i_cmd_finish_code;
    logic             o_trig_send;
    logic [10:0]      o_data_length;
    logic [7:0]       o_pck_ident;
    logic [7:0]       o_pck_idx;
    logic [7:0]       o_cur_byte;
    logic             i_feed_next_byte;
    logic             i_send_over;
    logic             o_rsp_overflow;
    logic [DESC_AW:0] o_pdu_pending;

    modport master (
        output i_data, i_wr, i_din, i_pdu_size, i_cmd, i_cmd_finish, i_cmd_finish_code,
               i_feed_next_byte, i_send_over,
        input  o_full, o_trig_send, o_data_length, o_pck_ident, o_pck_idx, o_cur_byte,
               o_rsp_overflow, o_pdu_pending
    );

    modport slave (
        input  i_data, i_wr, i_din, i_pdu_size, i_cmd, i_cmd_finish, i_cmd_finish_code,
               i_feed_next_byte, i_send_over,
        output o_full, o_trig_send, o_data_length, o_pck_ident, o_pck_idx, o_cur_byte,
               o_rsp_overflow, o_pdu_pending
    );
endinterface

// File: rtl/eth_pdu_scheduler.sv
// Segments the acquisition byte stream into PDUs held in a byte ring plus a descriptor FIFO,
// and interleaves queued command-completion responses with data frames at PDU boundaries.
module eth_pdu_scheduler #(
    parameter int ADDR_WIDTH = 13,
    parameter int DESC_AW    = 2,
    parameter int PDU_MAX    = 1470
) (
    input logic                 i_clk,
    input logic                 i_rst,
    eth_pdu_scheduler_if.slave  io_bus
);
    localparam int RING  = 2 ** ADDR_WIDTH;
    localparam int DDEP  = 2 ** DESC_AW;
    localparam int DCW   = DESC_AW + 1;
    localparam int BCW   = ADDR_WIDTH + 1;
    localparam logic [10:0]    PMAX  = 11'(PDU_MAX);
    localparam logic [DCW-1:0] DFULL = DCW'(DDEP);
    localparam logic [BCW-1:0] BLIM  = BCW'(RING - 1);

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_DAT_LOAD = 6'b000010,
        S_RSP_LOAD = 6'b000100,
        S_TRIG     = 6'b001000,
        S_SEND     = 6'b010000,
        S_RELEASE  = 6'b100000
    } state_t;

    logic [7:0]            r_ring    [RING];
    logic [ADDR_WIDTH-1:0] r_d_addr  [DDEP];
    logic [10:0]           r_d_len   [DDEP];
    logic [7:0]            r_d_ident [DDEP];
    logic [7:0]            r_d_idx   [DDEP];
    logic [DESC_AW-1:0]    r_d_wp, r_d_rp;
    logic [DCW-1:0]        r_d_cnt;
    logic [ADDR_WIDTH-1:0] r_wptr, r_seg_start;
    logic [BCW-1:0]        r_bcnt;
    logic [10:0]           r_eff, r_seg_cnt;
    logic                  r_burst, r_full;
    logic [7:0]            r_ident, r_idx;

    logic                  r_fin_s1, r_fin_s2, r_fin_s3;
    logic [31:0]           r_rq [2];
    logic                  r_rq_wp, r_rq_rp, r_ovf;
    logic [1:0]            r_rq_cnt;

    state_t                r_state;
    logic                  r_is_rsp, r_trig;
    logic [10:0]           r_len, r_pos;
    logic [7:0]            r_o_ident, r_o_idx, r_cur;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [39:0]           r_rsp_sh;

    logic                  w_accept, w_first, w_close_full, w_close_end, w_push, w_pop;
    logic                  w_rsp_edge, w_rsp_push, w_rsp_pop;
    logic [10:0]           w_eff_now, w_eff_use, w_cnt_next, w_push_len;
    logic [DCW-1:0]        w_d_cnt_next;
    logic [BCW-1:0]        w_bcnt_next;
    logic [ADDR_WIDTH-1:0] w_rd_next;
    logic [31:0]           w_rsp_head;

    always_comb begin
        w_accept     = io_bus.i_wr & io_bus.i_din & ~r_full;
        w_first      = w_accept & ~r_burst;
        w_eff_now    = (io_bus.i_pdu_size == '0 || io_bus.i_pdu_size > PMAX) ? PMAX : io_bus.i_pdu_size;
        w_eff_use    = r_burst ? r_eff : w_eff_now;
        w_cnt_next   = r_seg_cnt + 11'd1;
        w_close_full = w_accept && (w_cnt_next == w_eff_use);
        w_close_end  = !io_bus.i_wr && r_burst && (r_seg_cnt != '0);
        w_push       = w_close_full | w_close_end;
        w_push_len   = w_close_full ? w_eff_use : r_seg_cnt;
        w_pop        = (r_state == S_RELEASE) && !r_is_rsp;
        w_rsp_pop    = (r_state == S_RELEASE) && r_is_rsp;
        w_rsp_edge   = r_fin_s2 & ~r_fin_s3;
        w_rsp_push   = w_rsp_edge && (r_rq_cnt != 2'd2);
        w_d_cnt_next = r_d_cnt + DCW'(w_push) - DCW'(w_pop);
        // Accepted byte and data-frame release may land in the same cycle.
        w_bcnt_next  = r_bcnt + BCW'(w_accept) - (w_pop ? BCW'(r_d_len[r_d_rp]) : '0);
        w_rd_next    = r_rd_addr + 1'b1;
        w_rsp_head   = r_rq[r_rq_rp];
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) r_ring[r_wptr] <= io_bus.i_data;
        if (w_push) begin
            r_d_addr[r_d_wp]  <= r_seg_start;
            r_d_len[r_d_wp]   <= w_push_len;
            r_d_ident[r_d_wp] <= r_ident;
            r_d_idx[r_d_wp]   <= r_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0; r_seg_start <= '0; r_seg_cnt <= '0; r_eff <= '0; r_burst <= 1'b0;
            r_ident <= '0; r_idx <= '0; r_d_wp <= '0; r_d_rp <= '0; r_d_cnt <= '0;
            r_bcnt <= '0; r_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr  <= r_wptr + 1'b1;
                r_burst <= 1'b1;
                if (w_first) r_eff <= w_eff_now;
                if (w_close_full) begin
                    r_seg_cnt   <= '0;
                    r_seg_start <= r_wptr + 1'b1;
                    r_idx       <= r_idx + 1'b1;
                end else begin
                    r_seg_cnt <= w_cnt_next;
                end
            end
            // Burst end: flushes a partial PDU (via w_close_end) and advances the burst identifier.
            if (!io_bus.i_wr && r_burst) begin
                r_burst     <= 1'b0;
                r_seg_cnt   <= '0;
                r_seg_start <= r_wptr;
                r_ident     <= r_ident + 1'b1;
                r_idx       <= '0;
            end
            if (w_push) r_d_wp <= r_d_wp + 1'b1;
            if (w_pop)  r_d_rp <= r_d_rp + 1'b1;
            r_d_cnt <= w_d_cnt_next;
            r_bcnt  <= w_bcnt_next;
            r_full  <= (w_d_cnt_next == DFULL) || (w_bcnt_next >= BLIM);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fin_s1 <= 1'b0; r_fin_s2 <= 1'b0; r_fin_s3 <= 1'b0;
            r_rq_wp <= 1'b0; r_rq_rp <= 1'b0; r_rq_cnt <= '0; r_ovf <= 1'b0;
        end else begin
            r_fin_s1 <= io_bus.i_cmd_finish;
            r_fin_s2 <= r_fin_s1;
            r_fin_s3 <= r_fin_s2;
            if (w_rsp_push) begin
                r_rq[r_rq_wp] <= {io_bus.i_cmd, io_bus.i_cmd_finish_code};
                r_rq_wp       <= ~r_rq_wp;
            end
            if (w_rsp_edge && !w_rsp_push) r_ovf <= 1'b1;
            if (w_rsp_pop) r_rq_rp <= ~r_rq_rp;
            r_rq_cnt <= r_rq_cnt + 2'(w_rsp_push) - 2'(w_rsp_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE; r_is_rsp <= 1'b0; r_trig <= 1'b0; r_len <= '0; r_pos <= '0;
            r_o_ident <= '0; r_o_idx <= '0; r_cur <= '0; r_rd_addr <= '0; r_rsp_sh <= '0;
        end else begin
            r_trig <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_rq_cnt != 2'd0)   r_state <= S_RSP_LOAD;
                    else if (r_d_cnt != '0) r_state <= S_DAT_LOAD;
                end
                S_DAT_LOAD: begin
                    r_is_rsp  <= 1'b0;
                    r_len     <= r_d_len[r_d_rp];
                    r_o_ident <= r_d_ident[r_d_rp];
                    r_o_idx   <= r_d_idx[r_d_rp];
                    r_rd_addr <= r_d_addr[r_d_rp];
                    r_cur     <= r_ring[r_d_addr[r_d_rp]];
                    r_pos     <= '0;
                    r_trig    <= 1'b1;
                    r_state   <= S_TRIG;
                end
                S_RSP_LOAD: begin
                    r_is_rsp  <= 1'b1;
                    r_len     <= 11'd6;
                    r_o_ident <= 8'hFF;
                    r_o_idx   <= 8'hFF;
                    r_cur     <= w_rsp_head[31:24];
                    r_rsp_sh  <= {w_rsp_head[23:16], ~w_rsp_head[31:24], ~w_rsp_head[23:16],
                                  w_rsp_head[15:0]};
                    r_pos     <= '0;
                    r_trig    <= 1'b1;
                    r_state   <= S_TRIG;
                end
                S_TRIG, S_SEND: begin
                    if (r_state == S_SEND && io_bus.i_send_over) begin
                        r_state <= S_RELEASE;
                    end else begin
                        r_state <= S_SEND;
                        // Lookahead read keeps the next byte ready the cycle after each feed.
                        if (io_bus.i_feed_next_byte && (r_pos + 11'd1 < r_len)) begin
                            r_pos <= r_pos + 11'd1;
                            if (r_is_rsp) begin
                                r_cur    <= r_rsp_sh[39:32];
                                r_rsp_sh <= {r_rsp_sh[31:0], 8'h00};
                            end else begin
                                r_rd_addr <= w_rd_next;
                                r_cur     <= r_ring[w_rd_next];
                            end
                        end
                    end
                end
                S_RELEASE: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.o_full         = r_full;
    assign io_bus.o_trig_send    = r_trig;
    assign io_bus.o_data_length  = r_len;
    assign io_bus.o_pck_ident    = r_o_ident;
    assign io_bus.o_pck_idx      = r_o_idx;
    assign io_bus.o_cur_byte     = r_cur;
    assign io_bus.o_rsp_overflow = r_ovf;
    assign io_bus.o_pdu_pending  = r_d_cnt;
endmodule

// File: tb/tb_eth_pdu_scheduler.sv
// Directed bench for eth_pdu_scheduler: acts as stream source and frame sender,
// checking frames against a scoreboard of expected PDUs and responses.
module tb_eth_pdu_scheduler;
    localparam int PMAX = 1470;

    typedef struct {
        int          len;
        logic [7:0]  ident;
        logic [7:0]  idx;
        bit          is_rsp;
        logic [15:0] cmd;
        logic [15:0] code;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_pdu_scheduler_if #(.DESC_AW(2)) bus ();

    eth_pdu_scheduler #(.ADDR_WIDTH(13), .DESC_AW(2), .PDU_MAX(1470)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus.slave)
    );

    int          checks = 0;
    int          failures = 0;
    int          trig_pending = 0;
    frame_t      exp_frames[$];
    logic [7:0]  exp_bytes[$];
    int          m_size, m_eff, m_seg;
    bit          m_burst;
    logic [7:0]  m_ident, m_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.o_trig_send) trig_pending++;
    endtask

    task automatic push_frame(input int len, input logic [7:0] ident, input logic [7:0] idx,
                              input bit is_rsp, input logic [15:0] cmd, input logic [15:0] code);
        frame_t f;
        f.len = len; f.ident = ident; f.idx = idx; f.is_rsp = is_rsp; f.cmd = cmd; f.code = code;
        exp_frames.push_back(f);
    endtask

    function automatic logic [7:0] rsp_byte(input frame_t f, input int j);
        case (j)
            0:       return f.cmd[15:8];
            1:       return f.cmd[7:0];
            2:       return ~f.cmd[15:8];
            3:       return ~f.cmd[7:0];
            4:       return f.code[15:8];
            default: return f.code[7:0];
        endcase
    endfunction

    task automatic begin_burst(input int size);
        m_size = size;
        bus.i_pdu_size = 11'(size);
        bus.i_wr = 1'b1;
        bus.i_din = 1'b0;
    endtask

    task automatic push_bytes(input int n);
        for (int k = 0; k < n; k++) begin
            logic [7:0] d;
            int stall;
            stall = 0;
            d = 8'($urandom_range(0, 255));
            bus.i_data = d;
            bus.i_din = 1'b1;
            while (bus.o_full && stall < 40) begin
                tick();
                stall++;
            end
            if (bus.o_full) begin
                chk("accept_stall", 32'(bus.o_full), 32'd0);
                bus.i_din = 1'b0;
                return;
            end
            tick();
            exp_bytes.push_back(d);
            if (!m_burst) begin
                m_burst = 1'b1;
                m_eff = (m_size == 0 || m_size > PMAX) ? PMAX : m_size;
            end
            m_seg++;
            if (m_seg == m_eff) begin
                push_frame(m_seg, m_ident, m_idx, 1'b0, 16'h0, 16'h0);
                m_idx++;
                m_seg = 0;
            end
        end
        bus.i_din = 1'b0;
    endtask

    task automatic end_burst();
        bus.i_wr = 1'b0;
        tick();
        if (m_seg > 0) push_frame(m_seg, m_ident, m_idx, 1'b0, 16'h0, 16'h0);
        if (m_burst) begin
            m_ident++;
            m_idx = 8'd0;
        end
        m_burst = 1'b0;
        m_seg = 0;
    endtask

    task automatic wait_trig(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (trig_pending > 0) begin
                trig_pending--;
                ok = 1'b1;
                return;
            end
            tick();
        end
        chk("trig_timeout", 32'(bus.o_trig_send), 32'd1);
    endtask

    task automatic pulse_finish(input logic [15:0] cmd, input logic [15:0] code);
        bus.i_cmd = cmd;
        bus.i_cmd_finish_code = code;
        bus.i_cmd_finish = 1'b1;
        repeat (4) tick();
        bus.i_cmd_finish = 1'b0;
        repeat (4) tick();
    endtask

    task automatic consume_frame(input int inject_at, input int n_edges,
                                 input logic [15:0] cmd_base, input logic [15:0] code_base);
        bit ok;
        frame_t f;
        logic [7:0] eb, last;
        last = 8'h00;
        wait_trig(ok);
        if (exp_frames.size() == 0) return;
        f = exp_frames.pop_front();
        if (!ok) begin
            if (!f.is_rsp) repeat (f.len) void'(exp_bytes.pop_front());
            return;
        end
        chk("length", 32'(bus.o_data_length), 32'(f.len));
        chk("ident", 32'(bus.o_pck_ident), 32'(f.ident));
        chk("idx", 32'(bus.o_pck_idx), 32'(f.idx));
        for (int j = 0; j < f.len; j++) begin
            eb = f.is_rsp ? rsp_byte(f, j) : exp_bytes.pop_front();
            chk(f.is_rsp ? "rsp_byte" : "data_byte", 32'(bus.o_cur_byte), 32'(eb));
            last = eb;
            if (j == inject_at) begin
                for (int e = 0; e < n_edges; e++) begin
                    pulse_finish(cmd_base + 16'(e), code_base + 16'(e));
                    if (e < 2) push_frame(6, 8'hFF, 8'hFF, 1'b1, cmd_base + 16'(e), code_base + 16'(e));
                end
            end
            if (j < f.len - 1) begin
                bus.i_feed_next_byte = 1'b1;
                tick();
                bus.i_feed_next_byte = 1'b0;
            end
        end
        bus.i_feed_next_byte = 1'b1;
        tick();
        bus.i_feed_next_byte = 1'b0;
        chk("feed_past_end", 32'(bus.o_cur_byte), 32'(last));
        bus.i_send_over = 1'b1;
        tick();
        bus.i_send_over = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        frame_t f6;
        rst = 1'b1;
        bus.i_data = '0; bus.i_wr = 1'b0; bus.i_din = 1'b0; bus.i_pdu_size = '0;
        bus.i_cmd = '0; bus.i_cmd_finish = 1'b0; bus.i_cmd_finish_code = '0;
        bus.i_feed_next_byte = 1'b0; bus.i_send_over = 1'b0;
        m_size = 0; m_eff = PMAX; m_seg = 0; m_burst = 1'b0; m_ident = '0; m_idx = '0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_full", 32'(bus.o_full), 32'd0);
        chk("rst_trig", 32'(bus.o_trig_send), 32'd0);
        chk("rst_len", 32'(bus.o_data_length), 32'd0);
        chk("rst_ident", 32'(bus.o_pck_ident), 32'd0);
        chk("rst_idx", 32'(bus.o_pck_idx), 32'd0);
        chk("rst_byte", 32'(bus.o_cur_byte), 32'd0);
        chk("rst_ovf", 32'(bus.o_rsp_overflow), 32'd0);
        chk("rst_pending", 32'(bus.o_pdu_pending), 32'd0);

        // Default size, 3000 bytes: 1470 + 1470 + 60.
        begin_burst(0);
        push_bytes(3000);
        end_burst();
        chk("t1_pending", 32'(bus.o_pdu_pending), 32'd3);
        repeat (3) consume_frame(-1, 0, 16'h0, 16'h0);

        // Burst ending exactly on a PDU boundary: no empty trailing frame.
        begin_burst(100);
        push_bytes(200);
        end_burst();
        repeat (2) consume_frame(-1, 0, 16'h0, 16'h0);
        repeat (10) tick();
        chk("t2_no_extra_frame", 32'(trig_pending), 32'd0);
        chk("t2_pending", 32'(bus.o_pdu_pending), 32'd0);

        // Response arriving mid-frame is sent after the data frame.
        begin_burst(0);
        push_bytes(50);
        end_burst();
        consume_frame(25, 1, 16'h1234, 16'h0001);
        consume_frame(-1, 0, 16'h0, 16'h0);
        chk("t3_ovf", 32'(bus.o_rsp_overflow), 32'd0);

        // Three finish edges during a frame: two queued, one dropped.
        begin_burst(0);
        push_bytes(20);
        end_burst();
        consume_frame(5, 3, 16'hA000, 16'h0100);
        repeat (2) consume_frame(-1, 0, 16'h0, 16'h0);
        chk("t4_ovf", 32'(bus.o_rsp_overflow), 32'd1);

        // Back-pressure with the sender stalled on the first PDU.
        begin_burst(0);
        push_bytes(3 * PMAX);
        chk("t5_full_before", 32'(bus.o_full), 32'd0);
        push_bytes(PMAX);
        chk("t5_full_after4", 32'(bus.o_full), 32'd1);
        chk("t5_pending4", 32'(bus.o_pdu_pending), 32'd4);
        consume_frame(-1, 0, 16'h0, 16'h0);
        for (int i = 0; i < 2; i++) if (bus.o_full) tick();
        chk("t5_full_fall", 32'(bus.o_full), 32'd0);
        push_bytes(PMAX);
        end_burst();
        repeat (4) consume_frame(-1, 0, 16'h0, 16'h0);

        // Reset in SEND after 10 feeds.
        begin_burst(0);
        push_bytes(20);
        end_burst();
        wait_trig(ok);
        f6 = exp_frames.pop_front();
        chk("t6_len", 32'(bus.o_data_length), 32'(f6.len));
        for (int j = 0; j < 10; j++) begin
            chk("t6_byte", 32'(bus.o_cur_byte), 32'(exp_bytes.pop_front()));
            bus.i_feed_next_byte = 1'b1;
            tick();
            bus.i_feed_next_byte = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_full", 32'(bus.o_full), 32'd0);
        chk("t6_trig", 32'(bus.o_trig_send), 32'd0);
        chk("t6_len0", 32'(bus.o_data_length), 32'd0);
        chk("t6_ident", 32'(bus.o_pck_ident), 32'd0);
        chk("t6_idx", 32'(bus.o_pck_idx), 32'd0);
        chk("t6_byte0", 32'(bus.o_cur_byte), 32'd0);
        chk("t6_ovf", 32'(bus.o_rsp_overflow), 32'd0);
        chk("t6_pending", 32'(bus.o_pdu_pending), 32'd0);
        exp_frames.delete();
        exp_bytes.delete();
        m_ident = '0; m_idx = '0; m_seg = 0; m_burst = 1'b0;
        trig_pending = 0;
        bus.i_send_over = 1'b1;
        tick();
        bus.i_send_over = 1'b0;
        repeat (3) tick();
        chk("t6_no_trig_after_rst", 32'(trig_pending), 32'd0);
        begin_burst(0);
        push_bytes(8);
        end_burst();
        consume_frame(-1, 0, 16'h0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
